pll_phase_ctrl: RTL and testbench



---
 rtl/pll_phase_ctrl_if.sv | 13 +
 rtl/pll_phase_ctrl.sv | 129 ++++++++++++
 tb/tb_pll_phase_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_phase_ctrl_if.sv
// Request channel into the PLL phase-shift sequencer: one phase-adjust command
// per valid/ready handshake.
`timescale 1ns/1ps
interface pll_phase_ctrl_if #(parameter int CNT_W = 8);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_sel;
  logic             req_dir;
  logic [CNT_W-1:0] req_steps;

  modport master (output req_valid, req_sel, req_dir, req_steps, input req_ready);
  modport slave  (input req_valid, req_sel, req_dir, req_steps, output req_ready);
endinterface

// File: rtl/pll_phase_ctrl.sv
// ECP5 PLL dynamic phase-shift sequencer: holds PHASESEL/PHASEDIR, issues timed
// active-low PHASESTEP pulses, then waits for LOCK to report done or err.
`timescale 1ns/1ps
module pll_phase_ctrl #(
  parameter int SETUP_CYC   = 4,
  parameter int PULSE_CYC   = 4,
  parameter int GAP_CYC     = 8,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  pll_phase_ctrl_if.slave  req,
  input  logic             pll_locked,
  output logic [1:0]       phasesel,
  output logic             phasedir,
  output logic             phasestep,
  output logic             busy,
  output logic [CNT_W-1:0] steps_left,
  output logic             done,
  output logic             err
);
  localparam int MAX_A = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_B = (GAP_CYC > TIMEOUT_CYC) ? GAP_CYC : TIMEOUT_CYC;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  // +1 so a power-of-two maximum still fits the SETTLE reload of TIMEOUT_CYC
  localparam int TW    = $clog2(MAX_C + 1);

  localparam logic [TW-1:0] LD_SETUP  = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] LD_PULSE  = TW'(PULSE_CYC - 1);
  localparam logic [TW-1:0] LD_GAP    = TW'(GAP_CYC - 1);
  localparam logic [TW-1:0] LD_SETTLE = TW'(TIMEOUT_CYC);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, GAP, SETTLE} state_t;

  state_t           state, state_n;
  logic [1:0]       lock_sync;
  logic             lock_s;
  logic [TW-1:0]    cnt, cnt_n;
  logic [CNT_W-1:0] steps_n;
  logic [1:0]       sel_n;
  logic             dir_n;
  logic             abort, abort_n;
  logic             done_n, err_n;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lock_sync <= '0;
    else        lock_sync <= {lock_sync[0], pll_locked};

  assign lock_s        = lock_sync[1];
  assign req.req_ready = (state == IDLE) & lock_s;
  assign busy          = (state != IDLE);

  always_comb begin
    state_n = state;
    cnt_n   = (cnt == '0) ? cnt : cnt - TW'(1);
    steps_n = steps_left;
    sel_n   = phasesel;
    dir_n   = phasedir;
    abort_n = abort;
    done_n  = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      IDLE: if (req.req_valid && req.req_ready) begin
        sel_n   = req.req_sel;
        dir_n   = req.req_dir;
        steps_n = req.req_steps;
        abort_n = 1'b0;
        state_n = SETUP;
        cnt_n   = LD_SETUP;
      end
      SETUP, GAP: begin
        // current lock_s counts too, so a drop on the final cycle still blocks the next pulse
        abort_n = abort | ~lock_s;
        if (cnt == '0) begin
          if (steps_left != '0 && !abort_n) begin
            state_n = PULSE;
            cnt_n   = LD_PULSE;
          end else begin
            state_n = SETTLE;
            cnt_n   = LD_SETTLE;
          end
        end
      end
      PULSE: begin
        abort_n = abort | ~lock_s;
        if (cnt == '0) begin
          steps_n = steps_left - CNT_W'(1);
          state_n = GAP;
          cnt_n   = LD_GAP;
        end
      end
      SETTLE: begin
        if (lock_s) begin
          done_n  = ~abort;
          err_n   = abort;
          state_n = IDLE;
        end else if (cnt == '0) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      steps_left <= '0;
      phasesel   <= '0;
      phasedir   <= 1'b0;
      phasestep  <= 1'b1;
      abort      <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      steps_left <= steps_n;
      phasesel   <= sel_n;
      phasedir   <= dir_n;
      phasestep  <= (state_n != PULSE);
      abort      <= abort_n;
      done       <= done_n;
      err        <= err_n;
    end
endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Bench for pll_phase_ctrl: per-scenario tasks push expected completions into a
// scoreboard; a negedge monitor pops and compares on every done/err pulse.
`timescale 1ns/1ps
module tb_pll_phase_ctrl;
  localparam int CNT_W = 8;
  localparam int TMO   = 100;
  localparam int PULSE = 4;

  logic clk = 1'b0, rst_n = 1'b0, pll_locked = 1'b0;
  logic [1:0] phasesel;
  logic phasedir, phasestep, busy, done, err;
  logic [CNT_W-1:0] steps_left;

  pll_phase_ctrl_if #(.CNT_W(CNT_W)) bus();

  pll_phase_ctrl #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req(bus), .pll_locked(pll_locked),
    .phasesel(phasesel), .phasedir(phasedir), .phasestep(phasestep),
    .busy(busy), .steps_left(steps_left), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {logic is_err; int cyc; int sl; int np; int fl;} exp_t;
  exp_t sb[$];
  exp_t e;
  int errors = 0, checks = 0;
  logic [1:0] exp_sel = 2'd0;
  logic exp_dir = 1'b0;

  // monitor state: rel = cycle index since accept (accept edge = 0)
  int rel = 0, npulses = 0, first_low = -1, run = 0;
  logic prev_ps = 1'b1, prev_busy = 1'b0, sel_ok = 1'b1;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_ps = 1'b1; prev_busy = 1'b0; run = 0;
    end else begin
      if (busy && !prev_busy) begin
        rel = 1; npulses = 0; first_low = -1; sel_ok = 1'b1;
      end else rel++;
      if (busy && (phasesel !== exp_sel || phasedir !== exp_dir)) sel_ok = 1'b0;
      if (!phasestep) begin
        if (prev_ps) begin
          npulses++;
          if (first_low < 0) first_low = rel;
        end
        run++;
      end else if (!prev_ps) begin
        checks++;
        if (run !== PULSE) begin
          errors++; $display("FAIL pulse_width: got %0d cycles, expected %0d", run, PULSE);
        end
        run = 0;
      end
      if (done || err) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_unexpected: done=%0b err=%0b with nothing pending", done, err);
        end else begin
          e = sb.pop_front();
          checks++;
          if ({done, err} !== {~e.is_err, e.is_err}) begin
            errors++; $display("FAIL sb_kind: done=%0b err=%0b, expected err=%0b", done, err, e.is_err);
          end
          checks++;
          if (rel !== e.cyc) begin
            errors++; $display("FAIL sb_cycle: completion on cycle %0d, expected %0d", rel, e.cyc);
          end
          checks++;
          if (int'(steps_left) !== e.sl) begin
            errors++; $display("FAIL sb_steps_left: got %0d, expected %0d", steps_left, e.sl);
          end
          checks++;
          if (npulses !== e.np) begin
            errors++; $display("FAIL sb_npulses: got %0d, expected %0d", npulses, e.np);
          end
          checks++;
          if (first_low !== e.fl) begin
            errors++; $display("FAIL sb_first_low: got cycle %0d, expected %0d", first_low, e.fl);
          end
          checks++;
          if (sel_ok !== 1'b1) begin
            errors++; $display("FAIL sb_sel_stable: phasesel/phasedir moved while busy, expected %0d/%0b", exp_sel, exp_dir);
          end
          checks++;
          if (busy !== 1'b0) begin
            errors++; $display("FAIL sb_busy: busy=%0b on completion cycle, expected 0", busy);
          end
        end
      end
      prev_ps = phasestep;
      prev_busy = busy;
    end
  end

  task automatic send(input logic [1:0] s, input logic d, input logic [CNT_W-1:0] n, input exp_t ex);
    int k = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_sel = s; bus.req_dir = d; bus.req_steps = n;
    exp_sel = s; exp_dir = d;
    sb.push_back(ex);
    while (!bus.req_ready && k < 50) begin @(negedge clk); k++; end
    checks++;
    if (!bus.req_ready) begin
      errors++; $display("FAIL send_accept: req_ready=%0b after %0d cycles, expected 1", bus.req_ready, k);
      bus.req_valid = 1'b0;
      void'(sb.pop_back());
    end else begin
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (sb.size() != 0 && k < 300) begin @(negedge clk); #1; k++; end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL %s_timeout: %0d results pending after %0d cycles, expected 0", tag, sb.size(), k);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pll_locked = 1'b0;
    bus.req_valid = 1'b0; bus.req_sel = 2'd0; bus.req_dir = 1'b0; bus.req_steps = '0;
    #12;
    checks++;
    if ({phasestep, busy, done, err} !== 4'b1000) begin
      errors++; $display("FAIL reset_outs: step/busy/done/err=%b, expected 1000", {phasestep, busy, done, err});
    end
    checks++;
    if ({phasesel, phasedir, steps_left} !== '0) begin
      errors++; $display("FAIL reset_regs: sel=%0d dir=%0b steps_left=%0d, expected 0", phasesel, phasedir, steps_left);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready_nolock: req_ready=%0b, expected 0", bus.req_ready);
    end
    pll_locked = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready_sync1: req_ready=%0b, expected 0", bus.req_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready_sync2: req_ready=%0b, expected 1", bus.req_ready);
    end
  endtask

  task automatic test_single();
    send(2'd0, 1'b0, 8'd1, exp_t'{1'b0, 18, 0, 1, 5});
    wait_idle("single");
  endtask

  task automatic test_multi();
    send(2'd2, 1'b1, 8'd3, exp_t'{1'b0, 42, 0, 3, 5});
    wait_idle("multi");
  endtask

  task automatic test_zero();
    send(2'd1, 1'b1, 8'd0, exp_t'{1'b0, 6, 0, 0, -1});
    wait_idle("zero");
  endtask

  task automatic test_abort();
    int k = 0;
    send(2'd3, 1'b0, 8'd5, exp_t'{1'b1, 40, 3, 2, 5});
    while (npulses != 2 && k < 60) begin @(negedge clk); #1; k++; end
    pll_locked = 1'b0;
    repeat (20) @(negedge clk);
    pll_locked = 1'b1;
    wait_idle("abort");
  endtask

  task automatic test_timeout_b2b();
    int k = 0;
    logic bad = 1'b0;
    send(2'd0, 1'b0, 8'd0, exp_t'{1'b1, TMO + 6, 0, 0, -1});
    pll_locked = 1'b0;
    wait_idle("timeout");
    bus.req_valid = 1'b1; bus.req_sel = 2'd1; bus.req_dir = 1'b0; bus.req_steps = '0;
    exp_sel = 2'd1; exp_dir = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.req_ready !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL b2b_nolock: accepted or ready while lock low, expected ready=0 busy=0");
    end
    pll_locked = 1'b1;
    sb.push_back(exp_t'{1'b0, 6, 0, 0, -1});
    do begin @(negedge clk); k++; end while (!bus.req_ready && k < 20);
    checks++;
    if (k !== 2) begin
      errors++; $display("FAIL b2b_ready_latency: ready after %0d cycles, expected 2", k);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    wait_idle("b2b");
  endtask

  task automatic test_reset_mid();
    int k = 0;
    send(2'd2, 1'b1, 8'd3, exp_t'{1'b0, 0, 0, 0, 0});
    while (phasestep !== 1'b0 && k < 40) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({phasestep, busy, done, err, bus.req_ready} !== 5'b10000) begin
      errors++; $display("FAIL rstmid_outs: step/busy/done/err/ready=%b, expected 10000",
                         {phasestep, busy, done, err, bus.req_ready});
    end
    checks++;
    if (steps_left !== '0) begin
      errors++; $display("FAIL rstmid_steps_left: got %0d, expected 0", steps_left);
    end
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_ready1: req_ready=%0b, expected 0", bus.req_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_ready2: req_ready=%0b, expected 1", bus.req_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_zero();
    test_abort();
    test_timeout_b2b();
    test_reset_mid();
    test_single();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1);
  end
endmodule
